register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Parametrised register bank: DEPTH words of WIDTH bits, one synchronous write port and
//   NREAD combinational read ports. Built from parametrised load-enable registers.
//   Supplies operands to the datapath (decode stage) and takes results from write-back.
//   Adds features a single register lacks: async reset, address decode, optional
//   hardwired-zero entry 0, optional write-through bypass.
// PARAMETERS
//   WIDTH      32   data bits per word
//   DEPTH      16   number of words (>=2; need not be a power of 2)
//   NREAD      2    number of read ports (>=1)
//   AW         $clog2(DEPTH)  address width (derived localparam, not overridable)
//   ZERO_REG   1    1: entry 0 always reads 0 and ignores writes
//   BYPASS     1    1: a read of the address being written this cycle returns wd
//   RESET_VAL  0    value loaded into every entry on reset
// PORTS
//   clk    in   1            rising-edge clock
//   rst_n  in   1            asynchronous active-low reset
//   we     in   1            write enable
//   wa     in   AW           write address
//   wd     in   WIDTH        write data
//   ra     in   NREAD*AW     read addresses; port i = ra[i*AW +: AW]
//   rd     out  NREAD*WIDTH  read data; port i = rd[i*WIDTH +: WIDTH]
// BEHAVIOUR
//   - Reset: rst_n low forces every entry to RESET_VAL immediately, independent of clk.
//     Entry 0 still reads 0 when ZERO_REG=1. rd follows the reset contents combinationally.
//   - Write: at a posedge clk with rst_n high and we=1, entry[wa] <= wd.
//     Write latency is 1 cycle. The new value is visible on rd after that edge.
//   - Writes are ignored when:
//     - wa >= DEPTH;
//     - ZERO_REG=1 and wa==0;
//     - rst_n is low at the edge (reset has priority over we).
//   - Read: rd[i] is combinational from ra[i]. Latency is 0 cycles.
//     - ra[i] >= DEPTH: rd[i] = 0.
//     - ZERO_REG=1 and ra[i]==0: rd[i] = 0.
//   - Bypass (BYPASS=1): if we=1, wa==ra[i] and the write is legal, rd[i] = wd in the same
//     cycle.
//     - An illegal write (zero reg, out of range) is never bypassed.
//     - No bypass while rst_n is low; rd shows the reset contents.
//   - BYPASS=0: rd[i] shows the old contents until the edge.
//   - Several read ports may address the same entry at once; each gets identical data.
//   - Reset released mid-cycle: the first write is taken at the next posedge with rst_n high.
//   - No state machine. Storage only; each entry's state is its register contents.
// STRUCTURE
//   - Shared package (processor-wide defs): register-file WIDTH/DEPTH defaults and the
//     hardwired-zero index constant.
//   - Sub-module: register_n #(WIDTH, RESET_VAL) (clk, rst_n, ld, d, q).
//     - Async active-low reset; loads d at posedge when ld=1.
//     - Instantiated DEPTH times in a generate loop.
//   - When ZERO_REG=1, entry 0's instance is omitted (constant 0).
//   - Write decoder: ld[k] = we & (wa==k) & legal.
//   - Read muxes and bypass compare are generated per port.
// TESTING
//   1. Reset: rst_n=0 with clk idle -> every ra reads 0 (RESET_VAL=0). Repeat with
//      RESET_VAL=32'hDEAD_BEEF: entries 1..15 read DEADBEEF, entry 0 reads 0.
//   2. Write/read: we=1, wa=5, wd=32'h12345768 at one edge, then we=0, wd=32'h11111111 ->
//      ra0=5 reads 12345768 on the following cycles; entry 5 unchanged.
//   3. Zero register: we=1, wa=0, wd=32'hFFFFFFFF -> rd at ra=0 stays 0, no bypass, no
//      other entry changes.
//   4. Bypass: BYPASS=1, entry 3 = 32'hA, we=1, wa=3, wd=32'hB, ra0=ra1=3 -> both ports read
//      B before the edge. With BYPASS=0 both read A before the edge and B after it.
//   5. Bounds: DEPTH=12, we=1, wa=13, wd=32'h55 -> no entry changes; ra=13 reads 0.
//      NREAD=3: ports on addresses 1, 2, 11 return independent data.
//   6. Reset mid-operation: write 32'h77 to entry 7, pull rst_n low between edges -> entry 7
//      reads 0 at once. A write issued while rst_n is low is lost. First write after
//      release lands at the next posedge.

Source files
------------

// File: rtl/register_file_pkg.sv
// Processor-wide register-file defaults shared by the decode and write-back stages.
package register_file_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_DEPTH    = 16;
  localparam int RF_ZERO_IDX = 0;

endpackage : register_file_pkg

// File: rtl/register_file_reg.sv
// Load-enable register with asynchronous active-low reset; one storage word of the bank.
module register_n #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule : register_n

// File: rtl/register_file.sv
// Register bank: DEPTH words x WIDTH bits, one synchronous write port, NREAD combinational
// read ports, optional hardwired-zero entry 0 and optional write-through bypass.
module register_file
  import register_file_pkg::*;
#(
  parameter int               WIDTH     = RF_WIDTH,
  parameter int               DEPTH     = RF_DEPTH,
  parameter int               NREAD     = 2,
  parameter int               ZERO_REG  = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd
);

  logic [WIDTH-1:0] entry [DEPTH];
  logic             legal_wr;

  // A write is legal only in range, off the hardwired-zero entry, and outside reset.
  // Gating with rst_n keeps the bypass quiet while the bank is held in reset.
  assign legal_wr = we && rst_n && (int'(wa) < DEPTH) &&
                    !((ZERO_REG != 0) && (int'(wa) == RF_ZERO_IDX));

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    if ((ZERO_REG != 0) && (k == RF_ZERO_IDX)) begin : g_zero
      assign entry[k] = '0;
    end else begin : g_reg
      logic ld;
      assign ld = legal_wr && (int'(wa) == k);

      register_n #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .d     (wd),
        .q     (entry[k])
      );
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    logic [AW-1:0]    ra_i;
    logic [WIDTH-1:0] rd_i;

    assign ra_i = ra[i*AW +: AW];

    // NOTE: assigning a default first keeps this combinational block from inferring a latch.
    always_comb begin
      rd_i = '0;
      if (int'(ra_i) < DEPTH) rd_i = entry[ra_i];
      if ((BYPASS != 0) && legal_wr && (wa == ra_i)) rd_i = wd;
    end

    assign rd[i*WIDTH +: WIDTH] = rd_i;
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: four parameter variants driven by one stimulus
// stream, checked against an array model every cycle plus hand-computed literal points.
module tb_register_file;

  // d0: defaults; d1: RESET_VAL=DEADBEEF; d2: BYPASS=0; d3: DEPTH=12, NREAD=3
  localparam int         NINST = 4;
  localparam int         DEP [NINST] = '{16, 16, 16, 12};
  localparam int         BP  [NINST] = '{1, 1, 0, 1};
  localparam logic [31:0] RV [NINST] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [7:0]  ra = '0;
  logic [11:0] ra3 = '0;
  logic [63:0] rd0, rd1, rd2;
  logic [95:0] rd3;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  logic [31:0] mem [NINST][16];

  always #5 if (clk_en) clk = ~clk;

  register_file u_d0 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd0)
  );

  register_file #(.RESET_VAL(32'hDEAD_BEEF)) u_d1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd1)
  );

  register_file #(.BYPASS(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd2)
  );

  register_file #(.DEPTH(12), .NREAD(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra3), .rd(rd3)
  );

  // Model: reset loads every word; a write lands only in range and off entry 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NINST; n++)
        for (int k = 0; k < 16; k++) mem[n][k] <= RV[n];
    end else if (we) begin
      for (int n = 0; n < NINST; n++)
        if (int'(wa) < DEP[n] && wa != 4'd0) mem[n][wa] <= wd;
    end
  end

  function automatic logic [31:0] exp_rd(input int inst, input int a);
    if (a >= DEP[inst] || a == 0) return 32'h0;
    if (BP[inst] != 0 && rst_n === 1'b1 && we === 1'b1 && int'(wa) == a) return wd;
    return mem[inst][a];
  endfunction

  function automatic logic [31:0] dut_rd(input int inst, input int p);
    case (inst)
      0:       return rd0[p*32 +: 32];
      1:       return rd1[p*32 +: 32];
      2:       return rd2[p*32 +: 32];
      default: return rd3[p*32 +: 32];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int n = 0; n < NINST; n++) begin
      int np = (n == 3) ? 3 : 2;
      for (int p = 0; p < np; p++) begin
        int a = (n == 3) ? int'(ra3[p*4 +: 4]) : int'(ra[p*4 +: 4]);
        check($sformatf("d%0d.p%0d@%0d", n, p, a), dut_rd(n, p), exp_rd(n, a));
      end
    end
  endtask

  always @(negedge clk) if (cmp_en) compare_all();

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ra(input logic [3:0] a);
    ra  = {a, a};
    ra3 = {a, a, a};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with clock idle: every address against the model, plus literal anchors.
    #1 rst_n = 1'b0;
    for (int a = 0; a < 16; a++) begin
      set_ra(4'(a));
      #1 compare_all();
    end
    set_ra(4'd7);
    #1;
    check("rst_d0_e7", rd0[31:0], 32'h0);
    check("rst_d1_e7", rd1[31:0], 32'hDEAD_BEEF);
    set_ra(4'd0);
    #1 check("rst_d1_e0", rd1[31:0], 32'h0);
    set_ra(4'd15);
    #1 check("rst_d1_e15", rd1[63:32], 32'hDEAD_BEEF);

    #1 rst_n = 1'b1;
    #1 clk_en = 1'b1;
    cmp_en = 1'b1;
    step();

    // Write / read back
    we = 1'b1; wa = 4'd5; wd = 32'h1234_5768; set_ra(4'd5);
    step();
    we = 1'b0; wd = 32'h1111_1111;
    step();
    check("wr_e5_d0", rd0[31:0], 32'h1234_5768);
    check("wr_e5_d2", rd2[63:32], 32'h1234_5768);

    // Zero register: never written, never bypassed
    we = 1'b1; wa = 4'd0; wd = 32'hFFFF_FFFF; set_ra(4'd0);
    #1 check("zero_nobyp", rd0[31:0], 32'h0);
    step();
    we = 1'b0;
    #1 check("zero_after", rd0[31:0], 32'h0);
    set_ra(4'd5);
    #1 check("zero_e5_kept", rd0[31:0], 32'h1234_5768);

    // Bypass vs no bypass
    we = 1'b1; wa = 4'd3; wd = 32'hA; set_ra(4'd3);
    step();
    wd = 32'hB;
    #1;
    check("byp_d0_p0", rd0[31:0], 32'hB);
    check("byp_d0_p1", rd0[63:32], 32'hB);
    check("nobyp_d2_p0", rd2[31:0], 32'hA);
    check("nobyp_d2_p1", rd2[63:32], 32'hA);
    step();
    we = 1'b0;
    #1;
    check("nobyp_d2_after", rd2[31:0], 32'hB);

    // Bounds on the DEPTH=12 variant
    we = 1'b1; wa = 4'd13; wd = 32'h55; set_ra(4'd13);
    step();
    wa = 4'd12; wd = 32'h66; set_ra(4'd12);
    step();
    we = 1'b0;
    #1;
    check("oob12_d3", rd3[31:0], 32'h0);
    check("inrange12_d0", rd0[31:0], 32'h66);
    set_ra(4'd13);
    #1 check("oob13_d3", rd3[95:64], 32'h0);

    // Three independent ports
    we = 1'b1;
    wa = 4'd1;  wd = 32'h111; step();
    wa = 4'd2;  wd = 32'h222; step();
    wa = 4'd11; wd = 32'hBBB; step();
    we = 1'b0;
    ra3 = {4'd11, 4'd2, 4'd1};
    #1;
    check("nr3_p0", rd3[31:0],  32'h111);
    check("nr3_p1", rd3[63:32], 32'h222);
    check("nr3_p2", rd3[95:64], 32'hBBB);

    // Reset mid-operation
    we = 1'b1; wa = 4'd7; wd = 32'h77; set_ra(4'd7);
    step();
    we = 1'b0;
    #1 check("e7_written", rd2[31:0], 32'h77);
    rst_n = 1'b0;
    #1;
    check("midrst_d0_e7", rd0[31:0], 32'h0);
    check("midrst_d1_e7", rd1[31:0], 32'hDEAD_BEEF);
    we = 1'b1; wa = 4'd9; wd = 32'h99; set_ra(4'd9);
    #1 check("rst_nobyp", rd0[31:0], 32'h0);
    step();
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("lost_wr_d2", rd2[31:0], 32'h0);
    check("lost_wr_d1", rd1[31:0], 32'hDEAD_BEEF);
    we = 1'b1;
    #1 check("post_rst_byp", rd0[31:0], 32'h99);
    step();
    we = 1'b0;
    #1 check("post_rst_wr", rd2[31:0], 32'h99);
    step();
    step();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_register_file
